// File: rtl/cpu_run_monitor_if.sv
// Run-control bus between the DLX top level and cpu_run_monitor.
// The master side issues commands and CPU fetch status; the slave side is the monitor.
interface cpu_run_monitor_if #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CYC_WIDTH = 20,
    parameter int unsigned NUM_BKPT  = 2
);
    logic                         start;
    logic                         resume;
    logic                         step;
    logic [PC_WIDTH-1:0]          pc_lim;
    logic [PC_WIDTH-1:0]          pc_in;
    logic                         pc_valid;
    logic [NUM_BKPT-1:0]          bkpt_en;
    logic [NUM_BKPT*PC_WIDTH-1:0] bkpt_addr;
    logic                         run_en;
    logic                         halted;
    logic [2:0]                   halt_cause;
    logic [2:0]                   bkpt_idx;
    logic [CYC_WIDTH-1:0]         cycle_count;
    logic [CYC_WIDTH-1:0]         retire_count;

    modport master (
        output start, resume, step, pc_lim, pc_in, pc_valid, bkpt_en, bkpt_addr,
        input  run_en, halted, halt_cause, bkpt_idx, cycle_count, retire_count
    );

    modport slave (
        input  start, resume, step, pc_lim, pc_in, pc_valid, bkpt_en, bkpt_addr,
        output run_en, halted, halt_cause, bkpt_idx, cycle_count, retire_count
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run-control block for the pipelined DLX CPU: gates the CPU clock enable and
// halts on PC limit, breakpoints, stalled-PC watchdog or cycle cap, with resume/step.
module cpu_run_monitor #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned CYC_WIDTH   = 20,
    parameter int unsigned MAX_CYCLES  = 500000,
    parameter int unsigned NUM_BKPT    = 2,
    parameter int unsigned STALL_LIMIT = 16
) (
    input logic              clk,
    input logic              rst_n,
    cpu_run_monitor_if.slave bus
);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_LIMIT = 3'd1;
    localparam logic [2:0] CAUSE_BKPT  = 3'd2;
    localparam logic [2:0] CAUSE_STALL = 3'd3;
    localparam logic [2:0] CAUSE_CAP   = 3'd4;
    localparam logic [2:0] CAUSE_STEP  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

    state_t               state_q, state_d;
    logic                 run_en_q, run_en_d;
    logic                 halted_q, halted_d;
    logic [2:0]           cause_q, cause_d;
    logic [2:0]           idx_q, idx_d;
    logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
    logic [CYC_WIDTH-1:0] ret_q, ret_d;
    logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 mask_q, mask_d;

    logic                 bk_hit;
    logic [2:0]           bk_idx;
    logic                 same_pc;
    logic                 stall_trip;
    logic [STALL_W-1:0]   stall_next;
    logic [CYC_WIDTH-1:0] cyc_inc;
    logic [CYC_WIDTH-1:0] ret_inc;
    logic [2:0]           hit_cause;
    logic                 resumable;

    // Halt condition evaluation for the current run cycle, highest priority first.
    always_comb begin
        bk_hit = 1'b0;
        bk_idx = 3'd0;
        for (int i = int'(NUM_BKPT) - 1; i >= 0; i--) begin
            if (bus.bkpt_en[i] &&
                bus.pc_in == bus.bkpt_addr[i*int'(PC_WIDTH) +: PC_WIDTH]) begin
                bk_hit = 1'b1;
                bk_idx = 3'(i);
            end
        end

        same_pc    = (bus.pc_in == last_pc_q);
        stall_next = same_pc ? stall_q + STALL_W'(1) : '0;
        stall_trip = same_pc && (stall_q == STALL_W'(STALL_LIMIT - 1));

        cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CYC_WIDTH'(1);
        ret_inc = (&ret_q) ? ret_q : ret_q + CYC_WIDTH'(1);

        hit_cause = CAUSE_NONE;
        if (bus.pc_valid) begin
            if (bus.pc_in >= bus.pc_lim)  hit_cause = CAUSE_LIMIT;
            else if (bk_hit && !mask_q)   hit_cause = CAUSE_BKPT;
            else if (stall_trip)          hit_cause = CAUSE_STALL;
        end
        if (hit_cause == CAUSE_NONE && cyc_inc == CYC_WIDTH'(MAX_CYCLES))
            hit_cause = CAUSE_CAP;

        resumable = (cause_q == CAUSE_BKPT) || (cause_q == CAUSE_STALL) ||
                    (cause_q == CAUSE_STEP);
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        last_pc_d = last_pc_q;
        stall_d   = stall_q;
        mask_d    = mask_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cause_d = CAUSE_NONE;
                    idx_d   = 3'd0;
                    cyc_d   = '0;
                    ret_d   = '0;
                    stall_d = '0;
                    mask_d  = 1'b0;
                end
            end
            RUN, STEP: begin
                if (bus.start) begin
                    state_d = RUN;
                    cause_d = CAUSE_NONE;
                    idx_d   = 3'd0;
                    cyc_d   = '0;
                    ret_d   = '0;
                    stall_d = '0;
                    mask_d  = 1'b0;
                end else begin
                    cyc_d  = cyc_inc;
                    mask_d = 1'b0;
                    if (bus.pc_valid) begin
                        ret_d     = ret_inc;
                        last_pc_d = bus.pc_in;
                        stall_d   = stall_next;
                    end
                    if (hit_cause != CAUSE_NONE) begin
                        state_d = HALTED;
                        cause_d = hit_cause;
                        if (hit_cause == CAUSE_BKPT) idx_d = bk_idx;
                    end else if (state_q == STEP) begin
                        state_d = HALTED;
                        cause_d = CAUSE_STEP;
                    end
                end
            end
            HALTED: begin
                if (bus.start) begin
                    state_d = RUN;
                    cause_d = CAUSE_NONE;
                    idx_d   = 3'd0;
                    cyc_d   = '0;
                    ret_d   = '0;
                    stall_d = '0;
                    mask_d  = 1'b0;
                end else if (bus.resume && resumable) begin
                    state_d = RUN;
                    stall_d = '0;
                    mask_d  = 1'b1;
                end else if (bus.step && resumable) begin
                    state_d = STEP;
                    stall_d = '0;
                    mask_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        run_en_d = (state_d == RUN) || (state_d == STEP);
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_en_q  <= 1'b0;
            halted_q  <= 1'b0;
            cause_q   <= CAUSE_NONE;
            idx_q     <= 3'd0;
            cyc_q     <= '0;
            ret_q     <= '0;
            last_pc_q <= '0;
            stall_q   <= '0;
            mask_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= run_en_d;
            halted_q  <= halted_d;
            cause_q   <= cause_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            last_pc_q <= last_pc_d;
            stall_q   <= stall_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.run_en       = run_en_q;
    assign bus.halted       = halted_q;
    assign bus.halt_cause   = cause_q;
    assign bus.bkpt_idx     = idx_q;
    assign bus.cycle_count  = cyc_q;
    assign bus.retire_count = ret_q;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: the bench acts as the CPU, advancing its
// fetch PC on each executed valid cycle, and checks against ramp-program predictions.
module tb_cpu_run_monitor;
    localparam int unsigned PW   = 32;
    localparam int unsigned CW   = 20;
    localparam int unsigned NB   = 2;
    localparam int unsigned MAXC = 50;
    localparam int unsigned SL   = 16;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_run_monitor_if #(.PC_WIDTH(PW), .CYC_WIDTH(CW), .NUM_BKPT(NB)) bus ();

    cpu_run_monitor #(
        .PC_WIDTH(PW), .CYC_WIDTH(CW), .MAX_CYCLES(MAXC), .NUM_BKPT(NB), .STALL_LIMIT(SL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;     // index of the next program PC the CPU fetches
    int ncyc     = 0;     // executed cycles since start, for the valid pattern
    int hold_k   = 100000;
    bit toggle   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: present the fetch PC, let the edge pass, advance if it retired.
    task automatic step_cpu();
        bit v;
        v = toggle ? (ncyc % 2 == 0) : 1'b1;
        bus.pc_valid = v;
        bus.pc_in    = BASE + 32'(4 * ((k < hold_k) ? k : hold_k));
        @(posedge clk); #1;
        if (v) k++;
        ncyc++;
    endtask

    task automatic run_cpu(input int budget, input string tag);
        for (int i = 0; i < budget && !bus.halted; i++) step_cpu();
        chk({tag, "_halted"}, 64'(bus.halted), 64'(1));
    endtask

    task automatic pulse(input int which);
        bus.start  = (which == 0);
        bus.resume = (which == 1);
        bus.step   = (which == 2);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.resume = 1'b0;
        bus.step   = 1'b0;
    endtask

    task automatic do_start();
        k    = 0;
        ncyc = 0;
        pulse(0);
    endtask

    // Ramp program prediction: PC = BASE + 4*k, always valid, no stall possible.
    function automatic void model_ramp(input logic [31:0] lim, input logic [1:0] en,
                                       input logic [31:0] a0, input logic [31:0] a1,
                                       input int c_in, input int k_in, input bit mask,
                                       output int cause, output int idx,
                                       output int c_out, output int k_out);
        int c;
        int kk;
        bit m;
        logic [31:0] pc;
        c = c_in; kk = k_in; m = mask;
        cause = 0; idx = 0;
        while (cause == 0 && c < 10000) begin
            pc = BASE + 32'(4 * kk);
            c++;
            if (pc >= lim) cause = 1;
            else if (!m && en[0] && pc == a0) begin cause = 2; idx = 0; end
            else if (!m && en[1] && pc == a1) begin cause = 2; idx = 1; end
            else if (c == int'(MAXC)) cause = 4;
            kk++;
            m = 1'b0;
        end
        c_out = c;
        k_out = kk;
    endfunction

    initial begin
        logic [31:0] lim, a0, a1;
        logic [1:0]  en;
        int cause, idx, c, kk, exp_idx;
        bit m;

        bus.start = 1'b0; bus.resume = 1'b0; bus.step = 1'b0;
        bus.pc_lim = '0; bus.pc_in = '0; bus.pc_valid = 1'b0;
        bus.bkpt_en = '0; bus.bkpt_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_run_en", 64'(bus.run_en), 64'(0));
        chk("rst_halted", 64'(bus.halted), 64'(0));
        chk("rst_cause",  64'(bus.halt_cause), 64'(0));
        chk("rst_idx",    64'(bus.bkpt_idx), 64'(0));
        chk("rst_cyc",    64'(bus.cycle_count), 64'(0));
        chk("rst_ret",    64'(bus.retire_count), 64'(0));
        rst_n = 1'b1;

        // resume/step ignored in IDLE
        pulse(1);
        chk("idle_resume", 64'(bus.run_en), 64'(0));
        pulse(2);
        chk("idle_step", 64'(bus.run_en), 64'(0));

        // PC limit halt
        bus.pc_lim = BASE + 32'h54;
        do_start();
        chk("lim_run_en", 64'(bus.run_en), 64'(1));
        run_cpu(60, "lim");
        chk("lim_cause", 64'(bus.halt_cause), 64'(1));
        chk("lim_cyc",   64'(bus.cycle_count), 64'(22));
        chk("lim_ret",   64'(bus.retire_count), 64'(22));
        chk("lim_pc",    64'(k - 1), 64'(21));
        chk("lim_run_en_low", 64'(bus.run_en), 64'(0));
        @(posedge clk); #1;
        chk("lim_cyc_hold", 64'(bus.cycle_count), 64'(22));
        pulse(1);
        chk("lim_resume_ign", 64'(bus.run_en), 64'(0));
        pulse(2);
        chk("lim_step_ign", 64'(bus.halted), 64'(1));

        // Breakpoint on channel 1, then resume through the same PC to the limit
        bus.bkpt_en   = 2'b10;
        bus.bkpt_addr = {BASE + 32'h10, BASE + 32'h200};
        do_start();
        run_cpu(60, "bk");
        chk("bk_cause", 64'(bus.halt_cause), 64'(2));
        chk("bk_idx",   64'(bus.bkpt_idx), 64'(1));
        chk("bk_cyc",   64'(bus.cycle_count), 64'(5));
        k = k - 1;
        pulse(1);
        chk("bk_resume_run", 64'(bus.run_en), 64'(1));
        run_cpu(60, "bk_res");
        chk("bk_res_cause", 64'(bus.halt_cause), 64'(1));
        chk("bk_res_cyc",   64'(bus.cycle_count), 64'(23));
        chk("bk_res_idx",   64'(bus.bkpt_idx), 64'(1));

        // Stall watchdog, single step, resume into another stall
        bus.bkpt_en = '0;
        bus.pc_lim  = 32'hFFFF_FFFF;
        hold_k = 8;
        do_start();
        run_cpu(60, "stall");
        chk("stall_cause", 64'(bus.halt_cause), 64'(3));
        chk("stall_cyc",   64'(bus.cycle_count), 64'(8 + 1 + SL));
        pulse(2);
        chk("step_run_en", 64'(bus.run_en), 64'(1));
        @(posedge clk); #1;
        chk("step_run_en_low", 64'(bus.run_en), 64'(0));
        chk("step_cause", 64'(bus.halt_cause), 64'(5));
        chk("step_cyc",   64'(bus.cycle_count), 64'(8 + 2 + SL));
        chk("step_ret",   64'(bus.retire_count), 64'(8 + 2 + SL));
        pulse(2);
        @(posedge clk); #1;
        chk("step2_cause", 64'(bus.halt_cause), 64'(5));
        chk("step2_cyc",   64'(bus.cycle_count), 64'(8 + 3 + SL));
        pulse(1);
        run_cpu(60, "stall2");
        chk("stall2_cause", 64'(bus.halt_cause), 64'(3));
        chk("stall2_cyc",   64'(bus.cycle_count), 64'(8 + 3 + 2 * SL));
        hold_k = 100000;

        // Cycle cap with alternating valid
        toggle = 1'b1;
        do_start();
        run_cpu(80, "cap");
        chk("cap_cause", 64'(bus.halt_cause), 64'(4));
        chk("cap_cyc",   64'(bus.cycle_count), 64'(MAXC));
        chk("cap_ret",   64'(bus.retire_count), 64'(MAXC / 2));
        pulse(1);
        chk("cap_resume_ign", 64'(bus.run_en), 64'(0));
        chk("cap_cyc_hold",   64'(bus.cycle_count), 64'(MAXC));
        toggle = 1'b0;

        // pc_limit outranks a simultaneous breakpoint
        bus.pc_lim    = BASE + 32'h18;
        bus.bkpt_en   = 2'b11;
        bus.bkpt_addr = {BASE + 32'h18, BASE + 32'h18};
        do_start();
        run_cpu(60, "prio");
        chk("prio_cause", 64'(bus.halt_cause), 64'(1));
        chk("prio_idx",   64'(bus.bkpt_idx), 64'(0));
        chk("prio_cyc",   64'(bus.cycle_count), 64'(7));

        // start while running restarts the counters
        bus.bkpt_en = '0;
        bus.pc_lim  = 32'hFFFF_FFFF;
        do_start();
        repeat (5) step_cpu();
        chk("rs_cyc_before", 64'(bus.cycle_count), 64'(5));
        bus.pc_valid = 1'b0;
        do_start();
        chk("rs_cyc_clr", 64'(bus.cycle_count), 64'(0));
        chk("rs_run_en",  64'(bus.run_en), 64'(1));
        repeat (3) step_cpu();
        chk("rs_cyc_after", 64'(bus.cycle_count), 64'(3));

        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run_en", 64'(bus.run_en), 64'(0));
        chk("arst_cyc",    64'(bus.cycle_count), 64'(0));
        chk("arst_ret",    64'(bus.retire_count), 64'(0));
        chk("arst_halted", 64'(bus.halted), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 64'(bus.run_en), 64'(0));
        bus.pc_lim = BASE + 32'h54;
        do_start();
        run_cpu(60, "arst_lim");
        chk("arst_lim_cause", 64'(bus.halt_cause), 64'(1));
        chk("arst_lim_cyc",   64'(bus.cycle_count), 64'(22));

        // Randomized ramp programs with breakpoints and resumes
        for (int it = 0; it < 8; it++) begin
            lim = BASE + 32'(4 * $urandom_range(0, 60));
            a0  = BASE + 32'(4 * $urandom_range(0, 40));
            a1  = BASE + 32'(4 * $urandom_range(0, 40));
            en  = 2'($urandom_range(0, 3));
            bus.pc_lim    = lim;
            bus.bkpt_en   = en;
            bus.bkpt_addr = {a1, a0};
            exp_idx = 0; c = 0; kk = 0; m = 1'b0;
            do_start();
            for (int ph = 0; ph < 4; ph++) begin
                model_ramp(lim, en, a0, a1, c, kk, m, cause, idx, c, kk);
                if (cause == 2) exp_idx = idx;
                run_cpu(80, "rnd");
                chk("rnd_cause", 64'(bus.halt_cause), 64'(cause));
                chk("rnd_idx",   64'(bus.bkpt_idx), 64'(exp_idx));
                chk("rnd_cyc",   64'(bus.cycle_count), 64'(c));
                chk("rnd_ret",   64'(bus.retire_count), 64'(c));
                if (cause != 2) break;
                k  = k - 1;
                kk = kk - 1;
                m  = 1'b1;
                pulse(1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
